// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: fetch state,
// sentinel words and the word-fetch legality check.
package instruction_fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = '0;
  localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  // A word fetch is legal when aligned and all four bytes lie inside memory;
  // the 33-bit sum keeps addresses near 2^32 from wrapping into range.
  function automatic logic word_fetch_ok(input logic [31:0] addr,
                                         input logic [32:0] last_byte);
    logic [32:0] end_addr;
    end_addr = {1'b0, addr} + 33'd3;
    return ((addr[1:0] & ALIGN_MASK) == 2'b00) && (end_addr <= last_byte);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_reg.sv
// Program counter with next-PC selection (reset, redirect, hold, +4) and the
// alignment/range checks for both the current PC and a redirect target.
module fetch_pc_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_target,
  input  logic [31:0] target,
  input  logic        advance,
  output logic [31:0] pc,
  output logic        pc_ok,
  output logic        target_ok
);

  localparam logic [32:0] LAST_BYTE = 33'(MEM_SIZE) - 33'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load_target) begin
      pc <= target;
    end else if (advance) begin
      pc <= pc + 32'd4;
    end
  end

  assign pc_ok     = word_fetch_ok(pc, LAST_BYTE);
  assign target_ok = word_fetch_ok(target, LAST_BYTE);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: presents the PC to instruction memory, registers the returned
// word into IF/ID and tracks RUN/HALT/FAULT.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_SIZE  = 1024,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fault_addr
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         pc_ok;
  logic         target_ok;
  logic         running;
  logic         is_halt_word;
  logic         redirect;
  logic         advance;

  always_comb begin
    running      = (state == ST_RUN);
    is_halt_word = (imem_instr == HALT_WORD);
    redirect     = running && branch_taken;
    // Only a clean, unstalled fetch of a non-sentinel word moves the PC on.
    advance      = running && !branch_taken && pc_ok && !is_halt_word && !stall;
  end

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .MEM_SIZE (MEM_SIZE)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .load_target (redirect),
    .target      (branch_target),
    .advance     (advance),
    .pc          (pc),
    .pc_ok       (pc_ok),
    .target_ok   (target_ok)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_RUN;
      ifid_valid    <= 1'b0;
      ifid_instr    <= NOP_WORD;
      ifid_pc       <= '0;
      ifid_pc_plus4 <= '0;
      halted        <= 1'b0;
      fault         <= 1'b0;
      fault_addr    <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (branch_taken) begin
            // Redirect wins over stall so the wrong-path word is squashed.
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_WORD;
            if (!target_ok) begin
              state      <= ST_FAULT;
              fault      <= 1'b1;
              fault_addr <= branch_target;
            end
          end else if (!pc_ok) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_WORD;
            state      <= ST_FAULT;
            fault      <= 1'b1;
            fault_addr <= pc;
          end else if (is_halt_word) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_WORD;
            state      <= ST_HALT;
            halted     <= 1'b1;
          end else if (!stall) begin
            ifid_valid    <= 1'b1;
            ifid_instr    <= imem_instr;
            ifid_pc       <= pc;
            ifid_pc_plus4 <= pc + 32'd4;
          end
        end
        default: begin
          ifid_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: a cycle-level reference model predicts every post-edge
// output; a monitor compares them one cycle after each rising edge.
module tb_instruction_fetch_unit;

  localparam int MEM_SIZE = 1024;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] addr;
    logic        halted;
    logic        fault;
    logic [31:0] faddr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        halted;
  logic        fault;
  logic [31:0] fault_addr;

  logic        rst2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_instr2;
  logic        ifid_valid2;
  logic [31:0] ifid_instr2;
  logic [31:0] ifid_pc2;
  logic [31:0] ifid_pc_plus4_2;
  logic        halted2;
  logic        fault2;
  logic [31:0] fault_addr2;

  logic [7:0]  mem [0:MEM_SIZE-1];
  logic [9:0]  midx;
  exp_t        sb_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;

  // Reference model state: mode 0=run, 1=halted, 2=faulted.
  logic [31:0] m_pc;
  int          m_mode;
  logic        m_v;
  logic [31:0] m_instr, m_ipc, m_ipc4, m_faddr;

  instruction_fetch_unit #(.RESET_PC(32'h0), .MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4), .halted(halted), .fault(fault),
    .fault_addr(fault_addr));

  instruction_fetch_unit #(.RESET_PC(32'd1016), .MEM_SIZE(MEM_SIZE)) dut2 (
    .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
    .stall(1'b0), .branch_taken(1'b0), .branch_target(32'h0),
    .ifid_valid(ifid_valid2), .ifid_instr(ifid_instr2), .ifid_pc(ifid_pc2),
    .ifid_pc_plus4(ifid_pc_plus4_2), .halted(halted2), .fault(fault2),
    .fault_addr(fault_addr2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Big-endian word read; addresses past the last full word read as zero.
  assign midx = imem_addr[9:0];
  assign imem_instr = (imem_addr <= 32'(MEM_SIZE - 4)) ?
      {mem[midx], mem[midx + 10'd1], mem[midx + 10'd2], mem[midx + 10'd3]} : 32'h0;
  assign imem_instr2 = {16'h1357, imem_addr2[15:0]};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    longint x;
    x = a;
    if (x > MEM_SIZE - 4) return 32'h0;
    return {mem[x], mem[x + 1], mem[x + 2], mem[x + 3]};
  endfunction

  function automatic bit legal(input logic [31:0] a);
    longint x;
    x = a;
    return (x % 4 == 0) && (x + 3 <= MEM_SIZE - 1);
  endfunction

  task automatic put_word(input int a, input logic [31:0] w);
    mem[a] = w[31:24]; mem[a + 1] = w[23:16]; mem[a + 2] = w[15:8]; mem[a + 3] = w[7:0];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of inputs and push the model's prediction for the next edge.
  task automatic step(input logic r, input logic b, input logic s, input logic [31:0] t);
    exp_t e;
    logic [31:0] w;
    @(negedge clk);
    rst = r; branch_taken = b; stall = s; branch_target = t;
    w = mem_word(m_pc);
    if (r) begin
      m_pc = 32'h0; m_mode = 0; m_v = 0; m_instr = 0; m_ipc = 0; m_ipc4 = 0; m_faddr = 0;
    end else if (m_mode == 0) begin
      if (b) begin
        m_v = 0; m_instr = 0; m_pc = t;
        if (!legal(t)) begin m_mode = 2; m_faddr = t; end
      end else if (!legal(m_pc)) begin
        m_v = 0; m_instr = 0; m_mode = 2; m_faddr = m_pc;
      end else if (w == 32'hFFFF_FFFF) begin
        m_v = 0; m_instr = 0; m_mode = 1;
      end else if (!s) begin
        m_v = 1; m_instr = w; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_pc = m_pc + 4;
      end
    end else begin
      m_v = 0;
    end
    e.valid = m_v; e.instr = m_instr; e.pc = m_ipc; e.pc4 = m_ipc4; e.addr = m_pc;
    e.halted = (m_mode == 1); e.fault = (m_mode == 2); e.faddr = m_faddr;
    sb_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("ifid_valid", 32'(ifid_valid), 32'(mon_e.valid));
      chk("ifid_instr", ifid_instr, mon_e.instr);
      chk("ifid_pc", ifid_pc, mon_e.pc);
      chk("ifid_pc_plus4", ifid_pc_plus4, mon_e.pc4);
      chk("imem_addr", imem_addr, mon_e.addr);
      chk("halted", 32'(halted), 32'(mon_e.halted));
      chk("fault", 32'(fault), 32'(mon_e.fault));
      chk("fault_addr", fault_addr, mon_e.faddr);
      if (ifid_valid)
        $display("issue pc=%h instr=%h", ifid_pc, ifid_instr);
    end
  end

  // Second instance: reset PC near the top of memory runs off the end.
  initial begin
    rst2 = 1'b1;
    @(posedge clk); #1;
    chk("r2_reset_addr", imem_addr2, 32'd1016);
    chk("r2_reset_valid", 32'(ifid_valid2), 32'd0);
    @(negedge clk); rst2 = 1'b0;
    @(posedge clk); #1;
    chk("r2_pc_1016", ifid_pc2, 32'd1016);
    chk("r2_valid_1016", 32'(ifid_valid2), 32'd1);
    chk("r2_instr_1016", ifid_instr2, 32'h1357_03F8);
    @(posedge clk); #1;
    chk("r2_pc_1020", ifid_pc2, 32'd1020);
    chk("r2_valid_1020", 32'(ifid_valid2), 32'd1);
    chk("r2_addr_1024", imem_addr2, 32'd1024);
    @(posedge clk); #1;
    chk("r2_fault", 32'(fault2), 32'd1);
    chk("r2_fault_addr", fault_addr2, 32'd1024);
    chk("r2_no_issue", 32'(ifid_valid2), 32'd0);
    @(posedge clk); #1;
    chk("r2_fault_hold", 32'(fault2), 32'd1);
    chk("r2_addr_frozen", imem_addr2, 32'd1024);
  end

  initial begin
    logic [31:0] t;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    m_pc = 0; m_mode = 0; m_v = 0; m_instr = 0; m_ipc = 0; m_ipc4 = 0; m_faddr = 0;
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'h00;
    put_word(0, 32'h0045_7820);
    put_word(4, 32'h202D_0030);
    put_word(8, 32'h8CC9_0005);
    put_word(12, 32'hACCC_000A);
    put_word(16, 32'h110A_0003);
    put_word(32, 32'hFFFF_FFFF);

    // Directed: reset, fetch, stall at PC=8, branch under stall into halt.
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 1, 32'h20);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 0, 32'h40); step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    // Misaligned redirect faults; later branches and stalls are ignored.
    step(0, 1, 0, 32'h22);
    step(0, 1, 1, 32'h8); step(0, 0, 1, 0); step(0, 0, 0, 0);
    step(1, 0, 0, 0);

    // Random program with occasional sentinels and random control inputs.
    for (int a = 0; a < MEM_SIZE; a += 4)
      put_word(a, ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : $urandom());
    for (int c = 0; c < 300; c++) begin
      case ($urandom_range(0, 5))
        0: t = {$urandom_range(0, 300), 2'b00};
        1: t = $urandom();
        2: t = 32'hFFFF_FFFC;
        default: t = {22'h0, $urandom_range(0, 255), 2'b00};
      endcase
      if ((m_mode != 0 && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0)
        step(1, 0, 0, 0);
      else
        step(0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, t);
    end
    step(1, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch-side initiator for the byte-addressed, big-endian instruction memory.
- Owns the PC and drives the word address to the instruction memory, which returns the instruction in the same cycle.
- Registers each fetched word into the IF/ID pipeline register with a valid flag.
- Handles decode stalls, branch redirects, the all-ones halt sentinel, and alignment/range faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_SIZE, 1024, instruction memory size in bytes; legal fetch requires PC+3 <= MEM_SIZE-1.
- HALT_WORD, 32'hFFFF_FFFF, sentinel instruction that stops fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_addr  out  32  byte address to instruction memory; always equals the current PC (combinational from the PC register).
- imem_instr  in  32  instruction word returned combinationally by memory.
- stall  in  1  decode cannot accept; hold the PC and the IF/ID register.
- branch_taken  in  1  redirect request from the branch unit.
- branch_target  in  32  byte address of the redirect.
- ifid_valid  out  1  IF/ID register holds a real instruction.
- ifid_instr  out  32  registered instruction.
- ifid_pc  out  32  address of ifid_instr.
- ifid_pc_plus4  out  32  ifid_pc + 4.
- halted  out  1  FSM is in HALT.
- fault  out  1  FSM is in FAULT.
- fault_addr  out  32  offending address, captured on entry to FAULT.

Behaviour:
- Reset is synchronous and active-high: on a rising edge with rst=1, PC<=RESET_PC, state<=RUN, and all ifid_* outputs, halted, fault and fault_addr go to 0 (ifid_instr=0 is a NOP). rst overrides every other input.
- States: RUN, HALT, FAULT. HALT and FAULT exit only via rst.
- Per-edge priority in RUN: branch_taken > fault check > halt check > stall > normal fetch.
- branch_taken=1:
  - PC<=branch_target; IF/ID gets a bubble (valid=0, instr=0).
  - Applies even when stall=1, so the wrong-path instruction is squashed.
  - If branch_target[1:0]!=0 or branch_target+3>MEM_SIZE-1: state<=FAULT, fault_addr<=branch_target.
- Fault check on the current PC: if PC[1:0]!=0 or PC+3>MEM_SIZE-1, then state<=FAULT, fault_addr<=PC, bubble into IF/ID. The PC is not advanced. This covers sequential run-off at MEM_SIZE (e.g. PC=1024) and 32-bit wrap.
- Halt check: if imem_instr==HALT_WORD, then state<=HALT, bubble into IF/ID (the sentinel is never issued), PC holds at the sentinel address.
- stall=1: PC and all ifid_* outputs hold.
- Normal fetch: ifid_instr<=imem_instr, ifid_pc<=PC, ifid_pc_plus4<=PC+4, ifid_valid<=1, PC<=PC+4.
- Latency: one cycle from PC presentation to the ifid_* update. Throughput is one instruction per cycle with no stalls.
- HALT and FAULT: PC frozen, ifid_valid=0, branch_taken and stall ignored, imem_addr keeps presenting the frozen PC.
- Arithmetic: all PC math is 32-bit unsigned. The range check uses a 33-bit sum so wrap is detected and never silently accepted.
- halted=(state==HALT) and fault=(state==FAULT) are both registered.

Decomposition:
- Shared package holds:
  - fetch state enum (RUN, HALT, FAULT)
  - NOP_WORD=32'h0
  - HALT_WORD default
  - word alignment mask 2'b11
  - instruction width 32
- One natural sub-module: fetch_pc_reg. It holds the PC register with next-PC mux (reset, branch, hold, +4) and the 33-bit alignment/range checker.
- FSM and IF/ID register stay in the top module.

Test Plan:
- Reset then release; memory[0..3]=00 45 78 20 → imem_addr=0 during reset, all outputs 0; one edge after release ifid_valid=1, ifid_instr=32'h0045_7820, ifid_pc=0, ifid_pc_plus4=4, imem_addr=4.
- Sequential fetch of words at 0,4,8,12,16 (0x0045_7820, 0x202D_0030, 0x8CC9_0005, 0xACCC_000A, 0x110A_0003) → five consecutive valid cycles with ifid_pc 0,4,8,12,16.
- Stall asserted for 3 cycles at PC=8 → ifid_pc stays 4 and imem_addr stays 8 throughout; fetch resumes at 8 on release.
- branch_taken with target 0x20 while stall=1, memory[32..35]=FF → next edge ifid_valid=0, PC=0x20; following edge halted=1, ifid_valid=0, imem_addr stays 0x20; a later branch_taken has no effect; rst returns to RUN at PC=0.
- branch_taken with target 0x22 → fault=1, fault_addr=0x22, ifid_valid=0; stall and branch ignored afterwards.
- RESET_PC=1016 with memory filled by non-halt words → valid fetches at 1016 and 1020, then fault=1 with fault_addr=1024 and no valid issue of address 1024.
